// File: rtl/multi_track_pwm_player.sv
// Multi-track sample player: walks one track of an external sample ROM at the
// sample rate and renders each volume-attenuated sample as PWM audio.
module multi_track_pwm_player #(
  parameter int CLK_FREQUENCY_HZ = 100000000,
  parameter int SAMPLE_RATE_HZ   = 8000,
  parameter int DATA_W           = 8,
  parameter int ADDR_W           = 15,
  parameter int NUM_TRACKS       = 4,
  parameter int TRK_W            = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [TRK_W-1:0]  track_sel,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] track_last,
  input  logic [2:0]        volume,
  output logic [TRK_W-1:0]  mem_track,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic              AUD_PWM,
  output logic              AUD_SD
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam int DIV_N = CLK_FREQUENCY_HZ / SAMPLE_RATE_HZ;
  localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic              start_ok;
  logic              loop_q;
  logic [ADDR_W-1:0] last_q;
  logic              load_q1;
  logic              load_q2;
  logic [2:0]        vol_q;
  logic [DATA_W-1:0] pwm_cnt;
  logic [DATA_W-1:0] pending_sample;
  logic [DATA_W-1:0] active_sample;

  assign tick     = (div_cnt == DIV_LAST);
  assign start_ok = start && (int'(track_sel) < NUM_TRACKS);
  assign busy     = (state == PLAY);
  assign AUD_SD   = busy;

  // Free-running sample divider, re-phased by every accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (start_ok || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_track <= '0;
      loop_q    <= 1'b0;
      last_q    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        state     <= PLAY;
        mem_addr  <= '0;
        mem_track <= track_sel;
        loop_q    <= loop_en;
        last_q    <= track_last;
      end else if (state == PLAY) begin
        if (stop) begin
          state <= IDLE;
        end else if (tick) begin
          if (mem_addr < last_q) begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end else if (loop_q) begin
            mem_addr <= '0;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

  // The capture trails each address update by the ROM's one-cycle read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q1        <= 1'b0;
      load_q2        <= 1'b0;
      pending_sample <= '0;
    end else begin
      load_q1 <= start_ok || (busy && tick);
      load_q2 <= load_q1;
      if (!busy) begin
        pending_sample <= '0;
      end else if (load_q2) begin
        pending_sample <= mem_data >> vol_q;
      end
    end
  end

  // New samples and volume take effect only at a PWM period boundary so a
  // period is never split between two duty values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt       <= '0;
      active_sample <= '0;
      vol_q         <= '0;
      AUD_PWM       <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DATA_W'(1);
      if (&pwm_cnt) begin
        active_sample <= pending_sample;
        vol_q         <= volume;
      end
      AUD_PWM <= busy && (pwm_cnt < active_sample);
    end
  end

endmodule

// File: doc/multi_track_pwm_player.md
MULTI_TRACK_PWM_PLAYER -- requirements
Module: multi_track_pwm_player

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CLK_FREQUENCY_HZ, 100000000, system clock frequency.
- SAMPLE_RATE_HZ, 8000, sample playback rate.
- DATA_W, 8, sample width and PWM resolution.
- ADDR_W, 15, sample address width per track.
- NUM_TRACKS, 4, number of selectable tracks (>=1).
- TRK_W, 2, track-select width (>= clog2(NUM_TRACKS), min 1).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse: begin playback of track_sel.
- stop, in, 1, one-cycle pulse: abort playback.
- track_sel, in, TRK_W, track to play; sampled on start.
- loop_en, in, 1, 1 = wrap at end of track; sampled on start.
- track_last, in, ADDR_W, last valid address of the selected track; sampled on start.
- volume, in, 3, attenuation as a right shift of 0..7; sampled at each PWM period boundary.
- mem_track, out, TRK_W, track index to the external sample ROM.
- mem_addr, out, ADDR_W, sample address to the ROM.
- mem_data, in, DATA_W, ROM read data, registered, valid 1 cycle after mem_addr.
- busy, out, 1, high while in PLAY.
- done, out, 1, one-cycle pulse when a non-looping track ends.
- AUD_PWM, out, 1, PWM audio output.
- AUD_SD, out, 1, amplifier enable (1 = on).

REQ-003 Clock and reset SHALL be exactly as fixed: one clock clk; reset asynchronous, active-low.

Function
REQ-004 The sample divider SHALL count 0..(CLK_FREQUENCY_HZ/SAMPLE_RATE_HZ - 1) and assert a one-cycle tick on the terminal count.
- It free-runs in every state.
- It clears to 0 on start.

REQ-005 The FSM SHALL have states IDLE and PLAY.
- IDLE -> PLAY on start.
- PLAY -> IDLE on stop.
- PLAY -> IDLE at end of track when the latched loop_en = 0.
- start in PLAY restarts playback from address 0 using the new track_sel, loop_en and track_last.

REQ-006 When start and stop are asserted in the same cycle, start SHALL win.

REQ-007 On start, mem_addr SHALL be set to 0 and mem_track SHALL be set to track_sel, on the next cycle.

REQ-008 In PLAY, on each tick mem_addr SHALL advance as follows.
- If mem_addr < latched track_last: mem_addr increments by 1.
- If mem_addr == track_last and loop = 1: mem_addr wraps to 0.
- If mem_addr == track_last and loop = 0: go to IDLE and pulse done for 1 cycle.

REQ-009 A track_last value of 0 SHALL play the single sample at address 0 repeatedly (loop = 1) or once (loop = 0).

REQ-010 One cycle after each tick, and one cycle after the start load, mem_data shifted right by volume SHALL be captured into pending_sample.

REQ-011 The PWM SHALL run on a free-running DATA_W-bit counter pwm_cnt.
- At pwm_cnt == all-ones, active_sample loads pending_sample.
- AUD_PWM = 1 exactly when pwm_cnt < active_sample, registered (1 cycle latency from the compare).
- A sample of 0 gives a constant-low output; the maximum sample gives high for 2^DATA_W - 1 of 2^DATA_W cycles.

REQ-012 In IDLE, pending_sample SHALL be 0 and AUD_PWM SHALL be 0.

REQ-013 AUD_SD SHALL equal busy.

REQ-014 track_sel >= NUM_TRACKS on start SHALL be ignored: no state change and no done pulse.

REQ-015 Changing track_sel, loop_en or track_last during PLAY SHALL have no effect until the next start.

Reset
REQ-016 While reset = 0, all of the following SHALL hold asynchronously:
- state = IDLE;
- divider, pwm_cnt, mem_addr, mem_track, pending_sample and active_sample = 0;
- AUD_PWM, AUD_SD, busy and done = 0.

REQ-017 Reset asserted mid-PLAY SHALL abort playback with no done pulse; after release the block stays in IDLE until start.

Verification
REQ-018 The bench SHALL cover these directed scenarios (sample period P = 12500 clocks at default parameters):
- Track 1, track_last = 3, loop = 0, ROM returns 8'h80: mem_addr steps 0,1,2,3 every 12500 clocks; AUD_PWM duty is 128/256; done pulses once; busy falls; AUD_PWM and AUD_SD end at 0.
- track_last = 2, loop = 1: mem_addr sequence 0,1,2,0,1,2...; no done pulse; busy stays 1.
- volume = 2 with sample 8'hFF: PWM high for 63 of every 256 cycles; sample 0: AUD_PWM constant 0.
- start and stop in the same cycle during PLAY: playback restarts at address 0, busy stays 1. stop alone: IDLE on the next cycle, no done pulse.
- track_sel = NUM_TRACKS: ignored, busy stays 0. reset pulsed mid-PLAY: all outputs 0 immediately, no done pulse.
